// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store front end and its lane formatter.
// Request sizes, FSM states and the alignment rule live here so every user agrees on them.
package mem_access_pkg;

   localparam int WORD_BYTES = 4;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_RSVD = 2'b11
   } Mem_size;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      ISSUE     = 2'b01,
      READ_WAIT = 2'b10,
      RESP      = 2'b11
   } State;

   function automatic logic misaligned(input Mem_size size, input logic [1:0] off);
      logic r;
      r = 1'b0;
      case (size)
         SIZE_HALF: r = off[0];
         SIZE_WORD: r = (off != 2'b00);
         default:   r = 1'b0;
      endcase
      return r;
   endfunction

   // Any request that must be answered with an error instead of a memory access.
   function automatic logic bad_request(input Mem_size size, input logic [1:0] off);
      return (size == SIZE_RSVD) || misaligned(size, off);
   endfunction

endpackage

// File: rtl/ram_if.sv
// Word-wide data memory port; the client issues en/we/be/addr/data_w and sees data_r one cycle
// after an accepted read, while delay=1 in the issue cycle means the access was not taken.
interface Ram_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) ();
   logic                    en;
   logic                    we;
   logic [DATA_WIDTH/8-1:0] be;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [DATA_WIDTH-1:0]   data_w;
   logic [DATA_WIDTH-1:0]   data_r;
   logic                    delay;

   modport client (output en, we, be, addr, data_w, input data_r, delay);
   modport server (input en, we, be, addr, data_w, output data_r, delay);
endinterface

// File: rtl/mem_lane_fmt.sv
// Combinational big-endian lane formatter: byte enables and lane-placed store data, plus
// load lane extraction with zero/sign extension. Byte offset 0 is bits 31:24 (be[3]).
module mem_lane_fmt
   import mem_access_pkg::*;
(
   input  Mem_size     i_size,
   input  logic [1:0]  i_off,
   input  logic        i_signed,
   input  logic [31:0] i_st_data,
   input  logic [31:0] i_ld_word,
   output logic [3:0]  o_be,
   output logic [31:0] o_wr_data,
   output logic [31:0] o_ld_data
);

   logic [7:0]  w_ld_byte;
   logic [15:0] w_ld_half;

   always_comb begin
      o_be      = 4'b0000;
      o_wr_data = '0;
      case (i_size)
         SIZE_BYTE: begin
            case (i_off)
               2'd0: begin o_be = 4'b1000; o_wr_data = {i_st_data[7:0], 24'h0};        end
               2'd1: begin o_be = 4'b0100; o_wr_data = {8'h0, i_st_data[7:0], 16'h0};  end
               2'd2: begin o_be = 4'b0010; o_wr_data = {16'h0, i_st_data[7:0], 8'h0};  end
               default: begin o_be = 4'b0001; o_wr_data = {24'h0, i_st_data[7:0]};     end
            endcase
         end
         SIZE_HALF: begin
            if (i_off[1]) begin
               o_be      = 4'b0011;
               o_wr_data = {16'h0, i_st_data[15:0]};
            end else begin
               o_be      = 4'b1100;
               o_wr_data = {i_st_data[15:0], 16'h0};
            end
         end
         SIZE_WORD: begin
            o_be      = 4'b1111;
            o_wr_data = i_st_data;
         end
         default: begin
            o_be      = 4'b0000;
            o_wr_data = '0;
         end
      endcase
   end

   always_comb begin
      w_ld_byte = 8'h0;
      case (i_off)
         2'd0:    w_ld_byte = i_ld_word[31:24];
         2'd1:    w_ld_byte = i_ld_word[23:16];
         2'd2:    w_ld_byte = i_ld_word[15:8];
         default: w_ld_byte = i_ld_word[7:0];
      endcase
      w_ld_half = i_off[1] ? i_ld_word[15:0] : i_ld_word[31:16];
   end

   always_comb begin
      o_ld_data = '0;
      case (i_size)
         SIZE_BYTE: o_ld_data = {{24{i_signed & w_ld_byte[7]}}, w_ld_byte};
         SIZE_HALF: o_ld_data = {{16{i_signed & w_ld_half[15]}}, w_ld_half};
         SIZE_WORD: o_ld_data = i_ld_word;
         default:   o_ld_data = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end: accepts one byte/half/word request at a time, drives the data memory,
// reissues stalled accesses up to MAX_RETRY times and returns exactly one response per request.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_RETRY  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   Ram_if.client       mem
);

   if (DATA_WIDTH != 32) begin : g_bad_width
      $error("mem_access_unit supports DATA_WIDTH=32 only");
   end

   localparam int RW = (MAX_RETRY > 2) ? $clog2(MAX_RETRY) : 1;
   localparam logic [RW-1:0] RETRY_LAST = (MAX_RETRY > 0) ? RW'(MAX_RETRY - 1) : '0;

   State                  r_state;
   State                  w_state_nxt;
   logic                  r_we;
   Mem_size               r_size;
   logic                  r_signed;
   logic [ADDR_WIDTH+1:0] r_addr;
   logic [31:0]           r_wdata;
   logic [RW-1:0]         r_retry;
   logic [31:0]           r_rsp_rdata;
   logic                  r_rsp_err;

   logic                  w_accept;
   logic                  w_req_bad;
   logic                  w_issue;
   logic                  w_abort;
   logic [3:0]            w_be;
   logic [31:0]           w_wr_data;
   logic [31:0]           w_ld_data;
   logic                  w_unused_addr;

   // Byte address bits above the memory's range wrap silently.
   assign w_unused_addr = ^req_addr[31:ADDR_WIDTH+2];

   assign req_ready = (r_state == IDLE) && !reset;
   assign w_accept  = req_valid && req_ready;
   assign w_req_bad = bad_request(Mem_size'(req_size), req_addr[1:0]);
   assign w_issue   = (r_state == ISSUE);

   always_comb begin
      w_state_nxt = r_state;
      w_abort     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) w_state_nxt = w_req_bad ? RESP : ISSUE;
         end
         ISSUE: begin
            if (mem.delay) begin
               if ((MAX_RETRY > 0) && (r_retry == RETRY_LAST)) begin
                  w_abort     = 1'b1;
                  w_state_nxt = RESP;
               end
            end else begin
               w_state_nxt = r_we ? RESP : READ_WAIT;
            end
         end
         READ_WAIT: w_state_nxt = RESP;
         RESP: begin
            if (rsp_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_retry     <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_issue && (w_state_nxt == ISSUE)) begin
            if (MAX_RETRY > 0) r_retry <= r_retry + 1'b1;
         end else begin
            r_retry <= '0;
         end
         // Response data starts at zero so stores and errors return 0 without extra muxing.
         if (w_accept) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= w_req_bad;
         end
         if (w_issue) r_rsp_err <= w_abort;
         if (r_state == READ_WAIT) r_rsp_rdata <= w_ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_we     <= req_we;
         r_size   <= Mem_size'(req_size);
         r_signed <= req_signed;
         r_addr   <= req_addr[ADDR_WIDTH+1:0];
         r_wdata  <= req_wdata;
      end
   end

   mem_lane_fmt u_lane_fmt (
      .i_size    (r_size),
      .i_off     (r_addr[1:0]),
      .i_signed  (r_signed),
      .i_st_data (r_wdata),
      .i_ld_word (mem.data_r),
      .o_be      (w_be),
      .o_wr_data (w_wr_data),
      .o_ld_data (w_ld_data)
   );

   assign mem.en     = w_issue;
   assign mem.we     = w_issue & r_we;
   assign mem.be     = w_issue ? w_be : '0;
   assign mem.addr   = w_issue ? r_addr[ADDR_WIDTH+1:2] : '0;
   assign mem.data_w = w_issue ? w_wr_data : '0;

   assign rsp_valid = (r_state == RESP);
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a small word memory with scripted stall cycles.
module tb_mem_access_unit;

   localparam logic [1:0] SB = 2'd0, SH = 2'd1, SW = 2'd2, SR = 2'd3;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   int total = 0;
   int bad   = 0;

   Ram_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) mem_if ();

   mem_access_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MAX_RETRY(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem        (mem_if)
   );

   always #5 clk = ~clk;

   // Memory model: accepted access when en && !delay; delay asserted for the first dly_target issues.
   logic [31:0] mem_arr [0:1023];
   int          en_total = 0;
   int          en_base  = 0;
   int          dly_target = 0;
   int          en_diff  = 0;
   logic        prev_en  = 1'b0;
   logic [46:0] prev_tuple = '0;

   assign mem_if.delay = mem_if.en && ((en_total - en_base) < dly_target);

   always @(posedge clk) begin
      if (mem_if.en) en_total <= en_total + 1;
      if (mem_if.en && !mem_if.delay) begin
         if (mem_if.we) begin
            for (int b = 0; b < 4; b++)
               if (mem_if.be[b]) mem_arr[mem_if.addr][b*8 +: 8] <= mem_if.data_w[b*8 +: 8];
         end else begin
            mem_if.data_r <= mem_arr[mem_if.addr];
         end
      end
      if (mem_if.en && prev_en &&
          ({mem_if.we, mem_if.be, mem_if.addr, mem_if.data_w} != prev_tuple))
         en_diff <= en_diff + 1;
      prev_en    <= mem_if.en;
      prev_tuple <= {mem_if.we, mem_if.be, mem_if.addr, mem_if.data_w};
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          dly;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
      int          exp_en;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                      input logic [31:0] wd, input int dly, input logic [31:0] rd, input logic er,
                      input int lat, input int nen);
      vt.push_back(vec_t'{we, sz, sg, a, wd, dly, rd, er, lat, nen});
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_req(input vec_t v, output logic [31:0] rd, output logic er,
                         output int lat, output int nen);
      int cyc;
      dly_target = v.dly;
      en_base    = en_total;
      req_we     = v.we;
      req_size   = v.size;
      req_signed = v.sgn;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      req_valid  = 1'b1;
      cyc = 0;
      while (!req_ready && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = ~req_wdata;
      lat = 1;
      while (!rsp_valid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      rd  = rsp_rdata;
      er  = rsp_err;
      nen = en_total - en_base;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready  = 1'b0;
      dly_target = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, hold_rd;
      logic        er;
      int          lat, nen, seen;

      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SB; req_signed = 1'b0;
      req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst req_ready", {31'h0, req_ready}, 32'h0);
      chk("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst rsp_rdata", rsp_rdata, 32'h0);
      chk("rst rsp_err",   {31'h0, rsp_err}, 32'h0);
      chk("rst mem", {mem_if.en, mem_if.we, mem_if.be, mem_if.addr}, 32'h0);
      chk("rst data_w", mem_if.data_w, 32'h0);
      reset = 1'b0;
      #1;
      chk("idle req_ready", {31'h0, req_ready}, 32'h1);
      @(posedge clk); #1;

      //   we    size sgn  addr          wdata       dly  exp_rd        err  lat en
      add(1'b1, SW, 1'b0, 32'h10,   32'hDEADBEEF, 0,  32'h0,        1'b0, 2, 1);
      add(1'b0, SW, 1'b0, 32'h10,   32'h0,        0,  32'hDEADBEEF, 1'b0, 3, 1);
      add(1'b1, SW, 1'b0, 32'h10,   32'h11223344, 0,  32'h0,        1'b0, 2, 1);
      add(1'b1, SB, 1'b0, 32'h13,   32'h000000A5, 0,  32'h0,        1'b0, 2, 1);
      add(1'b0, SW, 1'b0, 32'h10,   32'h0,        0,  32'h112233A5, 1'b0, 3, 1);
      add(1'b0, SB, 1'b1, 32'h13,   32'h0,        0,  32'hFFFFFFA5, 1'b0, 3, 1);
      add(1'b0, SB, 1'b0, 32'h13,   32'h0,        0,  32'h000000A5, 1'b0, 3, 1);
      add(1'b0, SB, 1'b1, 32'h10,   32'h0,        0,  32'h00000011, 1'b0, 3, 1);
      add(1'b1, SW, 1'b0, 32'h10,   32'hCAFE8001, 0,  32'h0,        1'b0, 2, 1);
      add(1'b0, SH, 1'b0, 32'h12,   32'h0,        0,  32'h00008001, 1'b0, 3, 1);
      add(1'b0, SH, 1'b1, 32'h12,   32'h0,        0,  32'hFFFF8001, 1'b0, 3, 1);
      add(1'b0, SH, 1'b1, 32'h10,   32'h0,        0,  32'hFFFFCAFE, 1'b0, 3, 1);
      add(1'b0, SH, 1'b0, 32'h10,   32'h0,        0,  32'h0000CAFE, 1'b0, 3, 1);
      add(1'b1, SH, 1'b0, 32'h10,   32'hABCD7E55, 0,  32'h0,        1'b0, 2, 1);
      add(1'b0, SW, 1'b0, 32'h10,   32'h0,        0,  32'h7E558001, 1'b0, 3, 1);
      add(1'b0, SW, 1'b0, 32'h12,   32'h0,        0,  32'h0,        1'b1, 1, 0);
      add(1'b0, SH, 1'b0, 32'h11,   32'h0,        0,  32'h0,        1'b1, 1, 0);
      add(1'b1, SW, 1'b0, 32'h13,   32'hFFFFFFFF, 0,  32'h0,        1'b1, 1, 0);
      add(1'b0, SR, 1'b0, 32'h10,   32'h0,        0,  32'h0,        1'b1, 1, 0);
      add(1'b0, SW, 1'b0, 32'h10,   32'h0,        3,  32'h7E558001, 1'b0, 6, 4);
      add(1'b1, SW, 1'b0, 32'h14,   32'h0BADF00D, 3,  32'h0,        1'b0, 5, 4);
      add(1'b0, SW, 1'b0, 32'h14,   32'h0,        0,  32'h0BADF00D, 1'b0, 3, 1);
      add(1'b1, SB, 1'b0, 32'h1017, 32'h0000005A, 0,  32'h0,        1'b0, 2, 1);
      add(1'b1, SB, 1'b0, 32'h15,   32'hFFFFFF77, 0,  32'h0,        1'b0, 2, 1);
      add(1'b0, SW, 1'b0, 32'h14,   32'h0,        0,  32'h0B77F05A, 1'b0, 3, 1);
      add(1'b1, SH, 1'b0, 32'h16,   32'hFFFF1234, 0,  32'h0,        1'b0, 2, 1);
      add(1'b0, SB, 1'b1, 32'h15,   32'h0,        0,  32'h00000077, 1'b0, 3, 1);
      add(1'b0, SB, 1'b0, 32'h16,   32'h0,        0,  32'h00000012, 1'b0, 3, 1);
      add(1'b0, SB, 1'b1, 32'h14,   32'h0,        0,  32'h0000000B, 1'b0, 3, 1);
      add(1'b1, SW, 1'b0, 32'h18,   32'h01020304, 0,  32'h0,        1'b0, 2, 1);
      add(1'b1, SW, 1'b0, 32'h18,   32'hFFFFFFFF, 100, 32'h0,       1'b1, 5, 4);
      add(1'b0, SW, 1'b0, 32'h18,   32'h0,        0,  32'h01020304, 1'b0, 3, 1);
      add(1'b0, SW, 1'b0, 32'h18,   32'h0,        1,  32'h01020304, 1'b0, 4, 2);

      foreach (vt[i]) begin
         do_req(vt[i], rd, er, lat, nen);
         chk($sformatf("vec%0d rdata", i), rd, vt[i].exp_rd);
         chk($sformatf("vec%0d err", i), {31'h0, er}, {31'h0, vt[i].exp_err});
         chk($sformatf("vec%0d latency", i), lat, vt[i].exp_lat);
         chk($sformatf("vec%0d en_pulses", i), nen, vt[i].exp_en);
      end
      chk("retry identical", en_diff, 32'h0);

      // Back-pressure: response held while rsp_ready=0, busy unit ignores a new request.
      en_base = en_total;
      req_we = 1'b0; req_size = SW; req_signed = 1'b0; req_addr = 32'h18; req_valid = 1'b1;
      @(posedge clk); #1;
      req_addr = 32'h10; req_size = SB;
      seen = 0;
      while (!rsp_valid && seen < 20) begin
         @(posedge clk); #1;
         seen++;
      end
      hold_rd = 32'h01020304;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("hold%0d rsp_valid", c), {31'h0, rsp_valid}, 32'h1);
         chk($sformatf("hold%0d rsp_rdata", c), rsp_rdata, hold_rd);
         chk($sformatf("hold%0d req_ready", c), {31'h0, req_ready}, 32'h0);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      chk("hold en_pulses", en_total - en_base, 32'h1);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("release rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("release req_ready", {31'h0, req_ready}, 32'h1);

      // Reset while stuck in ISSUE: access dropped, no response afterwards.
      dly_target = 1000;
      en_base = en_total;
      req_we = 1'b0; req_size = SW; req_addr = 32'h10; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("pre-reset en", {31'h0, mem_if.en}, 32'h1);
      reset = 1'b1;
      #1;
      chk("mid-reset en", {31'h0, mem_if.en}, 32'h0);
      chk("mid-reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("mid-reset req_ready", {31'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      dly_target = 0;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (rsp_valid || mem_if.en) seen++;
         @(posedge clk); #1;
      end
      chk("post-reset quiet", seen, 32'h0);
      chk("post-reset req_ready", {31'h0, req_ready}, 32'h1);

      do_req(vec_t'{1'b0, SW, 1'b0, 32'h18, 32'h0, 0, 32'h01020304, 1'b0, 3, 1}, rd, er, lat, nen);
      chk("after-reset load rdata", rd, 32'h01020304);
      chk("after-reset load latency", lat, 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
